// File: rtl/lsu_dbus_pkg.sv
// Shared memory-interface definitions: LSU op/fault/state enums, data-bus structs
// and the small decode helpers used when an operation is accepted.
package lsu_dbus_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } type_lsu_op_e;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    LD_MISALIGN = 2'd1,
    ST_MISALIGN = 2'd2,
    LD_TIMEOUT  = 2'd3
  } type_lsu_fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } type_lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  function automatic logic is_store(input type_lsu_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_aligned(input type_lsu_op_e op, input logic [1:0] lo);
    logic ok;
    case (op)
      LW, SW:       ok = (lo == 2'b00);
      LH, LHU, SH:  ok = ~lo[0];
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_sel(input type_lsu_op_e op, input logic [1:0] lo);
    logic [3:0] sel;
    case (op)
      LB, LBU, SB:  sel = 4'b0001 << lo;
      LH, LHU, SH:  sel = 4'b0011 << lo;
      default:      sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data is replicated across lanes so the target can pick any enabled lane.
  function automatic logic [31:0] store_data(input type_lsu_op_e op, input logic [31:0] wd);
    logic [31:0] d;
    case (op)
      SB:      d = {4{wd[7:0]}};
      SH:      d = {2{wd[15:0]}};
      SW:      d = wd;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to the load op.
module lsu_load_align
  import lsu_dbus_pkg::*;
(
  input  type_lsu_op_e op,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  word,
  output logic [31:0]  data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (op)
      LB:      data = {{24{byte_v[7]}}, byte_v};
      LBU:     data = {24'h0, byte_v};
      LH:      data = {{16{half_v[15]}}, half_v};
      LHU:     data = {16'h0, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_dbus.sv
// Load/store unit bus master: one operation at a time, IDLE -> REQ -> RESP.
// Stores are posted (one REQ cycle); loads wait for ack up to TIMEOUT_CYCLES.
module lsu_dbus
  import lsu_dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exe_valid_i,
  input  type_lsu_op_e    exe_op_i,
  input  logic [31:0]     exe_addr_i,
  input  logic [31:0]     exe_wdata_i,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic [31:0]     lsu_rdata_o,
  output type_lsu_fault_e lsu_fault_o,
  output type_dbus2peri_s lsu2dbus_o,
  input  type_peri2dbus_s dbus2lsu_i
);

  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT_CYCLES - 1);

  type_lsu_state_e state_q, state_d;
  type_lsu_op_e    op_q;
  type_lsu_fault_e fault_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      sel_q;
  logic            wen_q;
  logic [4:0]      cnt_q;
  logic [31:0]     rdata_q;
  logic [31:0]     load_val;

  logic accept;
  logic misalign;
  logic load_ack;
  logic store_done;
  logic timeout;

  lsu_load_align u_align (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .word    (dbus2lsu_i.r_data),
    .data    (load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    misalign   = 1'b0;
    load_ack   = 1'b0;
    store_done = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (exe_valid_i) begin
          if (is_aligned(exe_op_i, exe_addr_i[1:0])) begin
            accept  = 1'b1;
            state_d = REQ;
          end else begin
            misalign = 1'b1;
            state_d  = RESP;
          end
        end
      end
      REQ: begin
        // Stores complete on the write edge; ack is meaningless for them.
        if (wen_q) begin
          store_done = 1'b1;
          state_d    = RESP;
        end else if (dbus2lsu_i.ack) begin
          load_ack = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= LB;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      sel_q   <= 4'h0;
      wen_q   <= 1'b0;
      cnt_q   <= 5'h0;
      rdata_q <= 32'h0;
      fault_q <= NONE;
    end else begin
      if (accept) begin
        op_q    <= exe_op_i;
        addr_q  <= exe_addr_i;
        wdata_q <= store_data(exe_op_i, exe_wdata_i);
        sel_q   <= byte_sel(exe_op_i, exe_addr_i[1:0]);
        wen_q   <= is_store(exe_op_i);
        cnt_q   <= 5'h0;
      end else if (state_q == REQ && !wen_q && !dbus2lsu_i.ack) begin
        cnt_q <= cnt_q + 5'd1;
      end

      if (misalign) begin
        rdata_q <= 32'h0;
        fault_q <= is_store(exe_op_i) ? ST_MISALIGN : LD_MISALIGN;
      end else if (load_ack) begin
        rdata_q <= load_val;
        fault_q <= NONE;
      end else if (store_done) begin
        rdata_q <= 32'h0;
        fault_q <= NONE;
      end else if (timeout) begin
        rdata_q <= 32'h0;
        fault_q <= LD_TIMEOUT;
      end
    end
  end

  // req comes straight from the state register so reset removes it at once.
  always_comb begin
    lsu2dbus_o          = '0;
    lsu2dbus_o.addr     = addr_q;
    lsu2dbus_o.w_data   = wdata_q;
    lsu2dbus_o.sel_byte = sel_q;
    lsu2dbus_o.w_en     = wen_q;
    lsu2dbus_o.req      = (state_q == REQ);
  end

  assign lsu_stall_o = ((state_q == IDLE) && exe_valid_i) || (state_q == REQ);
  assign lsu_done_o  = (state_q == RESP);
  assign lsu_rdata_o = rdata_q;
  assign lsu_fault_o = fault_q;

endmodule

// File: tb/tb_lsu_dbus.sv
// Bench for lsu_dbus: memory target with programmable ack latency, reference
// model of byte-lane memory and load formatting, directed plus random operations.
module tb_lsu_dbus;
  import lsu_dbus_pkg::*;

  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            exe_valid = 1'b0;
  type_lsu_op_e    exe_op = LB;
  logic [31:0]     exe_addr = 32'h0;
  logic [31:0]     exe_wdata = 32'h0;
  logic            lsu_stall_o;
  logic            lsu_done_o;
  logic [31:0]     lsu_rdata_o;
  type_lsu_fault_e lsu_fault_o;
  type_dbus2peri_s lsu2dbus_o;
  type_peri2dbus_s dbus2lsu_i;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_lat = 0;
  int req_age = 0;
  logic ack_stray = 1'b0;

  logic [31:0] tmem    [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  lsu_dbus #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exe_valid_i (exe_valid),
    .exe_op_i    (exe_op),
    .exe_addr_i  (exe_addr),
    .exe_wdata_i (exe_wdata),
    .lsu_stall_o (lsu_stall_o),
    .lsu_done_o  (lsu_done_o),
    .lsu_rdata_o (lsu_rdata_o),
    .lsu_fault_o (lsu_fault_o),
    .lsu2dbus_o  (lsu2dbus_o),
    .dbus2lsu_i  (dbus2lsu_i)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'h80FF7F00 : (32'(i) * 32'h9E3779B1 + 32'h01234567);
  endfunction

  // Target memory: preset contents, then byte-lane writes on req & w_en edges.
  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (lsu2dbus_o.req && lsu2dbus_o.w_en)
        for (int i = 0; i < 4; i++)
          if (lsu2dbus_o.sel_byte[i])
            tmem[lsu2dbus_o.addr[9:2]][8*i +: 8] <= lsu2dbus_o.w_data[8*i +: 8];
    end
  end

  always @(posedge clk) req_age <= lsu2dbus_o.req ? req_age + 1 : 0;

  always_comb begin
    dbus2lsu_i.r_data = tmem[lsu2dbus_o.addr[9:2]];
    dbus2lsu_i.ack    = ack_stray | (lsu2dbus_o.req && (ack_lat >= 0) && (req_age >= ack_lat));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input type_lsu_op_e op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  // lat < 0 means the target never acks.
  task automatic run_op(input type_lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input bit hold, output logic [31:0] got_rd,
                        output logic [3:0] got_sel, output logic [31:0] got_wd);
    int sz, lane, exp_lat, exp_req, done_c, req_c;
    bit st, al, bad;
    logic [31:0] w, v, exp_rd, exp_wd, got_flt;
    logic [3:0]  exp_sel;
    type_lsu_fault_e exp_flt;

    sz   = size_of(op);
    st   = (op == SB) || (op == SH) || (op == SW);
    lane = int'(addr[1:0]);
    al   = (lane % sz) == 0;
    exp_sel = 4'h0;
    exp_wd  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= lane && i < lane + sz) exp_sel[i] = 1'b1;
      if (st) exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    w = ref_mem[addr[9:2]];
    exp_rd = 32'h0;
    if (!al) begin
      exp_flt = st ? ST_MISALIGN : LD_MISALIGN; exp_lat = 1; exp_req = 0;
    end else if (st) begin
      exp_flt = NONE; exp_lat = 2; exp_req = 1;
      for (int i = 0; i < 4; i++)
        if (exp_sel[i]) ref_mem[addr[9:2]][8*i +: 8] = wd[8*(i - lane) +: 8];
    end else if (lat < 0) begin
      exp_flt = LD_TIMEOUT; exp_lat = TO + 1; exp_req = TO;
    end else begin
      exp_flt = NONE; exp_lat = 2 + lat; exp_req = 1 + lat;
      v = w >> (8 * lane);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (op == LB && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (op == LH && v[15]) v = v | 32'hFFFF0000;
      end
      exp_rd = v;
    end

    @(negedge clk);
    exe_valid = 1'b1; exe_op = op; exe_addr = addr; exe_wdata = wd; ack_lat = lat;
    #1 chk("stall_on_valid", 32'(lsu_stall_o), 32'd1);
    done_c = 0; req_c = 0; bad = 0; got_sel = 4'h0; got_wd = 32'h0; got_rd = 32'h0;
    got_flt = 32'h0;
    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      @(negedge clk);
      if (!hold) exe_valid = 1'b0;
      if (lsu2dbus_o.req) begin
        req_c++;
        if (req_c == 1) begin got_sel = lsu2dbus_o.sel_byte; got_wd = lsu2dbus_o.w_data; end
        if (lsu2dbus_o.sel_byte !== exp_sel || lsu2dbus_o.w_data !== exp_wd ||
            lsu2dbus_o.addr !== addr || lsu2dbus_o.w_en !== st || lsu_stall_o !== 1'b1) bad = 1;
      end
      if (lsu_done_o) begin
        done_c = c; got_rd = lsu_rdata_o; got_flt = 32'(lsu_fault_o);
        if (lsu_stall_o !== 1'b0 || lsu2dbus_o.req !== 1'b0) bad = 1;
      end
    end
    exe_valid = 1'b0;
    chk("done_latency", 32'(done_c), 32'(exp_lat));
    chk("fault", got_flt, 32'(exp_flt));
    chk("rdata", got_rd, exp_rd);
    chk("req_cycles", 32'(req_c), 32'(exp_req));
    if (req_c > 0) chk("bus_fields", 32'(bad), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {30'h0, lsu_done_o, lsu2dbus_o.req}, 32'h0);
    chk("rdata_held", lsu_rdata_o, exp_rd);
  endtask

  initial begin
    logic [31:0] rd, wdv;
    logic [3:0]  sel;
    bit seen;
    type_lsu_op_e rop;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    #12;
    chk("rst_bus", {lsu2dbus_o.addr ^ lsu2dbus_o.w_data, 25'h0, lsu2dbus_o.sel_byte,
                    lsu2dbus_o.w_en, lsu2dbus_o.req, 1'b0} , 32'h0);
    chk("rst_addr", lsu2dbus_o.addr, 32'h0);
    chk("rst_wdata", lsu2dbus_o.w_data, 32'h0);
    chk("rst_ctrl", {26'h0, lsu2dbus_o.sel_byte, lsu2dbus_o.w_en, lsu2dbus_o.req}, 32'h0);
    chk("rst_status", {29'h0, lsu_done_o, lsu_stall_o, 1'b0}, 32'h0);
    chk("rst_rdata", lsu_rdata_o, 32'h0);
    chk("rst_fault", 32'(lsu_fault_o), 32'(NONE));
    @(negedge clk); rst_n = 1'b1;

    run_op(LB,  32'h102, 32'h0, 0, 0, rd, sel, wdv);
    chk("lb_102", rd, 32'hFFFFFFFF);
    run_op(LH,  32'h102, 32'h0, 1, 0, rd, sel, wdv);
    chk("lh_102", rd, 32'hFFFF80FF);
    run_op(LHU, 32'h100, 32'h0, 2, 0, rd, sel, wdv);
    chk("lhu_100", rd, 32'h00007F00);

    run_op(SB,  32'h103, 32'h000000AB, 0, 0, rd, sel, wdv);
    chk("sb_sel", 32'(sel), 32'h8);
    chk("sb_wdata", wdv, 32'hABABABAB);
    run_op(LBU, 32'h103, 32'h0, 0, 0, rd, sel, wdv);
    chk("lbu_103", rd, 32'h000000AB);

    run_op(LW, 32'h101, 32'h0, 0, 0, rd, sel, wdv);
    run_op(SH, 32'h203, 32'h1234, 0, 0, rd, sel, wdv);

    run_op(LW, 32'h040, 32'h0, -1, 0, rd, sel, wdv);
    run_op(LW, 32'h044, 32'h0, 0, 0, rd, sel, wdv);

    // Valid held through the whole operation must not start a second one.
    run_op(LW, 32'h048, 32'h0, 3, 1, rd, sel, wdv);
    run_op(SW, 32'h050, 32'hCAFEF00D, 0, 1, rd, sel, wdv);
    run_op(LW, 32'h050, 32'h0, 0, 0, rd, sel, wdv);
    chk("sw_lw_back", rd, 32'hCAFEF00D);

    ack_stray = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (lsu_done_o || lsu2dbus_o.req || lsu_stall_o) seen = 1;
    end
    ack_stray = 1'b0;
    chk("stray_ack_idle", 32'(seen), 32'd0);

    for (int k = 0; k < 40; k++) begin
      rop = type_lsu_op_e'($urandom_range(0, 7));
      run_op(rop, 32'($urandom_range(0, 1023)), $urandom, int'($urandom_range(0, 3)), 0, rd, sel, wdv);
    end

    // Reset in the middle of a load that is never acked.
    ack_lat = -1;
    @(negedge clk);
    exe_valid = 1'b1; exe_op = LW; exe_addr = 32'h0C8;
    @(negedge clk);
    exe_valid = 1'b0;
    chk("mid_req_up", 32'(lsu2dbus_o.req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(lsu2dbus_o.req), 32'd0);
    chk("mid_rst_bus", {26'h0, lsu2dbus_o.sel_byte, lsu2dbus_o.w_en, lsu_stall_o}, 32'h0);
    chk("mid_rst_addr", lsu2dbus_o.addr | lsu2dbus_o.w_data | lsu_rdata_o, 32'h0);
    chk("mid_rst_fault", 32'(lsu_fault_o), 32'(NONE));
    seen = 0;
    repeat (2) begin @(negedge clk); if (lsu_done_o) seen = 1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (lsu_done_o || lsu2dbus_o.req) seen = 1; end
    chk("mid_rst_no_done", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
